// File: rtl/line_buffer_if.sv
// rtl/line_buffer_if.sv - load/write/read/status bundle for line_buffer (rd_oob under LINE_BUFFER_OOB_CHECK_EN)
interface line_buffer_if #(
   parameter int DATA_W = 25,
   parameter int ADDR_W = 6
);
   logic              load_start;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_last;
   logic              wr_ready;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              loaded;
   logic [ADDR_W:0]   line_count;
   logic              overflow;
`ifdef LINE_BUFFER_OOB_CHECK_EN
   logic              rd_oob;
`endif

   modport master (
      output load_start, wr_valid, wr_data, wr_last, rd_en, rd_addr,
      input  wr_ready, rd_data, rd_valid, loaded, line_count, overflow
`ifdef LINE_BUFFER_OOB_CHECK_EN
      , input rd_oob
`endif
   );

   modport slave (
      input  load_start, wr_valid, wr_data, wr_last, rd_en, rd_addr,
      output wr_ready, rd_data, rd_valid, loaded, line_count, overflow
`ifdef LINE_BUFFER_OOB_CHECK_EN
      , output rd_oob
`endif
   );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - line store with IDLE/LOAD/DONE load FSM and 1-cycle registered reads; optional LINE_BUFFER_OOB_CHECK_EN
module line_buffer #(
   parameter int DATA_W = 25,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic         clk,
   input  logic         rst,
   line_buffer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              wr_ready_c;
   logic              loaded_c;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   line_count_q;
   logic              overflow_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic              wr_accept;
   logic              wr_full;
   logic              wr_end;
   logic [DATA_W-1:0] mem [DEPTH];

   // load_start outranks any write presented in the same cycle
   assign wr_accept = (state == LOAD) && bus.wr_valid && !bus.load_start;
   assign wr_full   = (wr_ptr == ADDR_W'(DEPTH - 1));
   assign wr_end    = wr_accept && (bus.wr_last || wr_full);

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and state-decoded outputs
   always_comb begin
      state_nxt  = state;
      wr_ready_c = 1'b0;
      loaded_c   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load_start) state_nxt = LOAD;
         end
         LOAD: begin
            wr_ready_c = 1'b1;
            if (bus.load_start) state_nxt = LOAD;
            else if (wr_end)    state_nxt = DONE;
         end
         DONE: begin
            loaded_c = 1'b1;
            if (bus.load_start) state_nxt = LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // write pointer, line count and sticky overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         line_count_q <= '0;
         overflow_q   <= 1'b0;
      end else if (bus.load_start) begin
         wr_ptr       <= '0;
         line_count_q <= '0;
         overflow_q   <= 1'b0;
      end else if (wr_accept) begin
         wr_ptr       <= wr_ptr + ADDR_W'(1);
         line_count_q <= line_count_q + (ADDR_W+1)'(1);
      end else if ((state == DONE) && bus.wr_valid) begin
         overflow_q   <= 1'b1;
      end
   end

   // line storage; deliberately not reset so old lines survive reloads and resets
   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr] <= bus.wr_data;
   end

`ifdef LINE_BUFFER_OOB_CHECK_EN
   logic rd_oob_q;
   logic rd_oob_c;

   assign rd_oob_c   = ({1'b0, bus.rd_addr} >= line_count_q);
   assign bus.rd_oob = rd_oob_q;

   // registered read; addresses past the current line count return zero and flag rd_oob
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_oob_q   <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         rd_oob_q   <= bus.rd_en && rd_oob_c;
         if (bus.rd_en) rd_data_q <= rd_oob_c ? '0 : mem[bus.rd_addr];
      end
   end
`else
   // registered read; array read sees pre-write contents when addresses collide
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
      end
   end
`endif

   assign bus.wr_ready   = wr_ready_c;
   assign bus.loaded     = loaded_c;
   assign bus.line_count = line_count_q;
   assign bus.overflow   = overflow_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;
endmodule

// File: tb/tb_line_buffer.sv
// tb/tb_line_buffer.sv - read-vector table, directed corner sequences and randomized model check for line_buffer
`timescale 1ns/1ps
module tb_line_buffer;
   localparam int DATA_W = 25;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   line_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   line_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // reference: a load is an append-only list of lines in an array
   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_loading;
   bit                m_loaded;
   bit                m_ovf;
   int                m_count;
   logic [DATA_W-1:0] m_rd_data;
   bit                m_rd_valid;
   bit                m_rd_oob;

   typedef struct {
      int                addr;
      logic [DATA_W-1:0] exp;
   } rd_vec_t;

   rd_vec_t rv [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rd_exp(input int addr, input int cnt, input logic [DATA_W-1:0] val);
      logic [DATA_W-1:0] r;
      r = val;
`ifdef LINE_BUFFER_OOB_CHECK_EN
      if (addr >= cnt) r = '0;
`endif
      return r;
   endfunction

   task automatic model_reset();
      m_loading  = 0;
      m_loaded   = 0;
      m_ovf      = 0;
      m_count    = 0;
      m_rd_data  = '0;
      m_rd_valid = 0;
      m_rd_oob   = 0;
   endtask

   task automatic model_step();
      int a;
      a = int'(bus.rd_addr);
      m_rd_valid = bus.rd_en;
      m_rd_oob   = 0;
      if (bus.rd_en) begin
         m_rd_data = rd_exp(a, m_count, m_mem[a]);
`ifdef LINE_BUFFER_OOB_CHECK_EN
         m_rd_oob = (a >= m_count);
`endif
      end
      if (bus.load_start) begin
         m_loading = 1;
         m_loaded  = 0;
         m_count   = 0;
         m_ovf     = 0;
      end else if (m_loading && bus.wr_valid) begin
         m_mem[m_count] = bus.wr_data;
         m_count++;
         if (bus.wr_last || m_count == DEPTH) begin
            m_loading = 0;
            m_loaded  = 1;
         end
      end else if (m_loaded && bus.wr_valid) begin
         m_ovf = 1;
      end
   endtask

   task automatic cycle();
      if (!rst) model_reset();
      else      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model();
      chk("rnd_wr_ready", 32'(bus.wr_ready), 32'(m_loading));
      chk("rnd_loaded", 32'(bus.loaded), 32'(m_loaded));
      chk("rnd_line_count", 32'(bus.line_count), m_count);
      chk("rnd_overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("rnd_rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
      chk("rnd_rd_data", 32'(bus.rd_data), 32'(m_rd_data));
`ifdef LINE_BUFFER_OOB_CHECK_EN
      chk("rnd_rd_oob", 32'(bus.rd_oob), 32'(m_rd_oob));
`endif
   endtask

   task automatic start_load();
      bus.load_start = 1'b1;
      cycle();
      bus.load_start = 1'b0;
   endtask

   task automatic write_line(input logic [DATA_W-1:0] d, input logic last);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      bus.wr_last  = last;
      cycle();
      bus.wr_valid = 1'b0;
      bus.wr_last  = 1'b0;
   endtask

   task automatic read_line(input int addr);
      bus.rd_en   = 1'b1;
      bus.rd_addr = ADDR_W'(addr);
      cycle();
      bus.rd_en   = 1'b0;
   endtask

   initial begin
      rst            = 1'b0;
      bus.load_start = 1'b0;
      bus.wr_valid   = 1'b0;
      bus.wr_data    = '0;
      bus.wr_last    = 1'b0;
      bus.rd_en      = 1'b0;
      bus.rd_addr    = '0;
      model_reset();

      for (int i = 0; i < 5; i++) begin
         rv[i].addr = i;
         rv[i].exp  = DATA_W'(i + 1);
      end

      // reset state
      cycle();
      cycle();
      chk("rst_wr_ready", 32'(bus.wr_ready), 0);
      chk("rst_loaded", 32'(bus.loaded), 0);
      chk("rst_line_count", 32'(bus.line_count), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_rd_data", 32'(bus.rd_data), 0);
      rst = 1'b1;
      cycle();
      chk("idle_wr_ready", 32'(bus.wr_ready), 0);

      // five-line load terminated by wr_last
      start_load();
      chk("load_wr_ready", 32'(bus.wr_ready), 1);
      for (int i = 1; i <= 5; i++) write_line(DATA_W'(i), logic'(i == 5));
      chk("five_loaded", 32'(bus.loaded), 1);
      chk("five_line_count", 32'(bus.line_count), 5);
      chk("five_wr_ready", 32'(bus.wr_ready), 0);
      for (int i = 0; i < 5; i++) begin
         read_line(rv[i].addr);
         chk("tbl_rd_valid", 32'(bus.rd_valid), 1);
         chk("tbl_rd_data", 32'(bus.rd_data), 32'(rv[i].exp));
      end
      cycle();
      chk("hold_rd_valid", 32'(bus.rd_valid), 0);
      chk("hold_rd_data", 32'(bus.rd_data), 5);

      // read and write of the same address in one cycle
      start_load();
      write_line(DATA_W'(32'h11), 1'b0);
      write_line(DATA_W'(32'h22), 1'b0);
      bus.wr_valid = 1'b1;
      bus.wr_data  = DATA_W'(32'hAAA);
      bus.wr_last  = 1'b1;
      bus.rd_en    = 1'b1;
      bus.rd_addr  = ADDR_W'(2);
      cycle();
      bus.wr_valid = 1'b0;
      bus.wr_last  = 1'b0;
      bus.rd_en    = 1'b0;
      chk("rbw_old_data", 32'(bus.rd_data), 32'(rd_exp(2, 2, DATA_W'(3))));
      chk("rbw_line_count", 32'(bus.line_count), 3);
      read_line(2);
      chk("rbw_new_data", 32'(bus.rd_data), 32'hAAA);

      // restart mid-load with a colliding write
      start_load();
      write_line(DATA_W'(32'h101), 1'b0);
      write_line(DATA_W'(32'h102), 1'b0);
      write_line(DATA_W'(32'h103), 1'b0);
      bus.load_start = 1'b1;
      bus.wr_valid   = 1'b1;
      bus.wr_data    = DATA_W'(32'h1ABCDEF);
      cycle();
      bus.load_start = 1'b0;
      bus.wr_valid   = 1'b0;
      chk("restart_line_count", 32'(bus.line_count), 0);
      chk("restart_wr_ready", 32'(bus.wr_ready), 1);
      write_line(DATA_W'(32'h55), 1'b0);
      chk("restart_cnt1", 32'(bus.line_count), 1);
      write_line(DATA_W'(32'h66), 1'b1);
      read_line(0);
      chk("restart_addr0", 32'(bus.rd_data), 32'(rd_exp(0, 2, DATA_W'(32'h55))));
      read_line(2);
      chk("kept_addr2", 32'(bus.rd_data), 32'(rd_exp(2, 2, DATA_W'(32'h103))));
      read_line(3);
      chk("kept_addr3", 32'(bus.rd_data), 32'(rd_exp(3, 2, DATA_W'(4))));

      // fill to capacity, then overflow
      start_load();
      for (int i = 0; i < DEPTH; i++) begin
         write_line(DATA_W'(32'h1000 + i), 1'b0);
         if (i == DEPTH - 2) chk("full_not_yet", 32'(bus.loaded), 0);
      end
      chk("full_loaded", 32'(bus.loaded), 1);
      chk("full_line_count", 32'(bus.line_count), 64);
      chk("full_overflow", 32'(bus.overflow), 0);
      write_line(DATA_W'(32'h1FFFFFF), 1'b0);
      chk("ovf_set", 32'(bus.overflow), 1);
      chk("ovf_line_count", 32'(bus.line_count), 64);
      read_line(0);
      chk("ovf_mem0", 32'(bus.rd_data), 32'h1000);

`ifdef LINE_BUFFER_OOB_CHECK_EN
      start_load();
      for (int i = 1; i <= 5; i++) write_line(DATA_W'(32'h200 + i), logic'(i == 5));
      read_line(7);
      chk("oob_data", 32'(bus.rd_data), 0);
      chk("oob_flag", 32'(bus.rd_oob), 1);
      chk("oob_valid", 32'(bus.rd_valid), 1);
      read_line(4);
      chk("inb_flag", 32'(bus.rd_oob), 0);
      chk("inb_data", 32'(bus.rd_data), 32'h205);
`endif

      // randomized traffic against the reference
      for (int n = 0; n < 600; n++) begin
         bus.load_start = ($urandom_range(15) == 0);
         bus.wr_valid   = $urandom_range(1);
         bus.wr_last    = ($urandom_range(7) == 0);
         bus.wr_data    = DATA_W'($urandom);
         bus.rd_en      = $urandom_range(1);
         bus.rd_addr    = ADDR_W'($urandom_range(DEPTH - 1));
         cycle();
         check_model();
      end
      bus.load_start = 1'b0;
      bus.wr_valid   = 1'b0;
      bus.wr_last    = 1'b0;
      bus.rd_en      = 1'b0;

      // asynchronous reset between edges during a load
      start_load();
      write_line(DATA_W'(32'h77), 1'b0);
      write_line(DATA_W'(32'h78), 1'b0);
      read_line(0);
      chk("pre_rst_rd_valid", 32'(bus.rd_valid), 1);
      chk("pre_rst_wr_ready", 32'(bus.wr_ready), 1);
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      chk("arst_wr_ready", 32'(bus.wr_ready), 0);
      chk("arst_line_count", 32'(bus.line_count), 0);
      chk("arst_rd_valid", 32'(bus.rd_valid), 0);
      chk("arst_rd_data", 32'(bus.rd_data), 0);
      chk("arst_loaded", 32'(bus.loaded), 0);
      cycle();
      rst = 1'b1;
      cycle();
      cycle();
      chk("post_rst_wr_ready", 32'(bus.wr_ready), 0);
      write_line(DATA_W'(32'h99), 1'b1);
      chk("idle_write_ignored", 32'(bus.line_count), 0);
      chk("idle_no_overflow", 32'(bus.overflow), 0);
      start_load();
      chk("post_rst_load", 32'(bus.wr_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
